// File: rtl/wb_regfile_pkg.sv
// rtl/wb_regfile_pkg.sv - shared widths and constants for the write-back register file
package wb_regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_regfile_mem_wb_latch.sv
// rtl/wb_regfile_mem_wb_latch.sv - MEM/WB pipeline register, loads every cycle
module mem_wb_latch
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_regwrite,
  input  logic              i_memtoreg,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [DATA_W-1:0] i_alu,
  input  logic [ADDR_W-1:0] i_wreg,
  output logic              o_regwrite,
  output logic              o_memtoreg,
  output logic [DATA_W-1:0] o_rdata,
  output logic [DATA_W-1:0] o_alu,
  output logic [ADDR_W-1:0] o_wreg
);

  logic              r_regwrite;
  logic              r_memtoreg;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_alu;
  logic [ADDR_W-1:0] r_wreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_regwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_rdata    <= '0;
      r_alu      <= '0;
      r_wreg     <= '0;
    end else begin
      r_regwrite <= i_regwrite;
      r_memtoreg <= i_memtoreg;
      r_rdata    <= i_rdata;
      r_alu      <= i_alu;
      r_wreg     <= i_wreg;
    end
  end

  assign o_regwrite = r_regwrite;
  assign o_memtoreg = r_memtoreg;
  assign o_rdata    = r_rdata;
  assign o_alu      = r_alu;
  assign o_wreg     = r_wreg;

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - MEM/WB latch, write-back select, register array, bypassed read ports
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_regwrite,
  input  logic              mem_memtoreg,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [DATA_W-1:0] mem_alu,
  input  logic [ADDR_W-1:0] mem_wreg,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              wb_regwrite,
  output logic [ADDR_W-1:0] wb_reg,
  output logic [DATA_W-1:0] wb_data
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic              w_regwrite;
  logic              w_memtoreg;
  logic [DATA_W-1:0] w_rdata;
  logic [DATA_W-1:0] w_alu;
  logic [ADDR_W-1:0] w_wreg;
  logic [DATA_W-1:0] w_wb_data;

  logic [DATA_W-1:0] r_regs [NREGS];

  mem_wb_latch #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_latch (
    .clk       (clk),
    .rst       (rst),
    .i_regwrite(mem_regwrite),
    .i_memtoreg(mem_memtoreg),
    .i_rdata   (mem_rdata),
    .i_alu     (mem_alu),
    .i_wreg    (mem_wreg),
    .o_regwrite(w_regwrite),
    .o_memtoreg(w_memtoreg),
    .o_rdata   (w_rdata),
    .o_alu     (w_alu),
    .o_wreg    (w_wreg)
  );

  assign w_wb_data   = w_memtoreg ? w_rdata : w_alu;
  assign wb_data     = w_wb_data;
  assign wb_regwrite = w_regwrite;
  assign wb_reg      = w_wreg;

  // Reset takes priority, so a write pending in the latch at the reset edge is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_regwrite && (w_wreg != ZERO_IDX)) begin
      r_regs[w_wreg] <= w_wb_data;
    end
  end

  always_comb begin
    rs_data = r_regs[rs_addr];
    if (rs_addr == ZERO_IDX) begin
      rs_data = '0;
    end else if (w_regwrite && (w_wreg == rs_addr)) begin
      rs_data = w_wb_data;
    end
  end

  always_comb begin
    rt_data = r_regs[rt_addr];
    if (rt_addr == ZERO_IDX) begin
      rt_data = '0;
    end else if (w_regwrite && (w_wreg == rt_addr)) begin
      rt_data = w_wb_data;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - directed vector bench for wb_regfile
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic        mem_regwrite;
  logic        mem_memtoreg;
  logic [31:0] mem_rdata;
  logic [31:0] mem_alu;
  logic [4:0]  mem_wreg;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        wb_regwrite;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;

  int n_tests = 0;
  int n_fail  = 0;

  wb_regfile dut (
    .clk         (clk),
    .rst         (rst),
    .mem_regwrite(mem_regwrite),
    .mem_memtoreg(mem_memtoreg),
    .mem_rdata   (mem_rdata),
    .mem_alu     (mem_alu),
    .mem_wreg    (mem_wreg),
    .rs_addr     (rs_addr),
    .rt_addr     (rt_addr),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .wb_regwrite (wb_regwrite),
    .wb_reg      (wb_reg),
    .wb_data     (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic        mtr;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [4:0]  wreg;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        e_rw;
    logic [4:0]  e_reg;
    logic [31:0] e_data;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rw, input logic mtr, input logic [31:0] rd,
                       input logic [31:0] alu, input logic [4:0] wreg);
    mem_regwrite = rw;
    mem_memtoreg = mtr;
    mem_rdata    = rd;
    mem_alu      = alu;
    mem_wreg     = wreg;
  endtask

  initial begin
    //            rw   mtr  rdata         alu           wreg  rs     rt     e_rw e_reg  e_data        e_rs          e_rt
    vecs[0]  = '{1'b1, 1'b0, 32'h0,        32'hDEADBEEF, 5'd8, 5'd8,  5'd0,  1'b1, 5'd8,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,        32'h0,        5'd0, 5'd8,  5'd8,  1'b0, 5'd0,  32'h0,        32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 1'b1, 32'h00001234, 32'hFFFFFFFF, 5'd31,5'd8,  5'd31, 1'b1, 5'd31, 32'h00001234, 32'hDEADBEEF, 32'h00001234};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,        32'h0,        5'd0, 5'd31, 5'd31, 1'b0, 5'd0,  32'h0,        32'h00001234, 32'h00001234};
    vecs[4]  = '{1'b1, 1'b0, 32'h0,        32'h5,        5'd0, 5'd0,  5'd0,  1'b1, 5'd0,  32'h5,        32'h0,        32'h0};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,        32'h0,        5'd0, 5'd0,  5'd0,  1'b0, 5'd0,  32'h0,        32'h0,        32'h0};
    vecs[6]  = '{1'b1, 1'b0, 32'h0,        32'hA,        5'd3, 5'd3,  5'd3,  1'b1, 5'd3,  32'hA,        32'hA,        32'hA};
    vecs[7]  = '{1'b1, 1'b0, 32'h0,        32'hB,        5'd3, 5'd3,  5'd3,  1'b1, 5'd3,  32'hB,        32'hB,        32'hB};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,        32'h0,        5'd0, 5'd3,  5'd8,  1'b0, 5'd0,  32'h0,        32'hB,        32'hDEADBEEF};
    vecs[9]  = '{1'b1, 1'b1, 32'hCAFE0000, 32'h1,        5'd8, 5'd8,  5'd31, 1'b1, 5'd8,  32'hCAFE0000, 32'hCAFE0000, 32'h00001234};
    vecs[10] = '{1'b0, 1'b0, 32'h0,        32'h0,        5'd0, 5'd8,  5'd3,  1'b0, 5'd0,  32'h0,        32'hCAFE0000, 32'hB};
    vecs[11] = '{1'b0, 1'b0, 32'h0,        32'h99,       5'd3, 5'd3,  5'd0,  1'b0, 5'd3,  32'h99,       32'hB,        32'h0};
    vecs[12] = '{1'b0, 1'b0, 32'h0,        32'h0,        5'd0, 5'd3,  5'd0,  1'b0, 5'd0,  32'h0,        32'hB,        32'h0};

    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    rs_addr = 5'd0;
    rt_addr = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_wb_regwrite", {31'b0, wb_regwrite}, 32'h0);
    check("reset_wb_reg", {27'b0, wb_reg}, 32'h0);
    check("reset_wb_data", wb_data, 32'h0);
    for (int i = 0; i < 32; i++) begin
      rs_addr = 5'(i);
      rt_addr = 5'(31 - i);
      #1;
      check($sformatf("reset_rs[%0d]", i), rs_data, 32'h0);
      check($sformatf("reset_rt[%0d]", 31 - i), rt_data, 32'h0);
    end
    rst = 1'b0;

    for (int v = 0; v < 13; v++) begin
      drive(vecs[v].rw, vecs[v].mtr, vecs[v].rdata, vecs[v].alu, vecs[v].wreg);
      rs_addr = vecs[v].rs;
      rt_addr = vecs[v].rt;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_wb_regwrite", v), {31'b0, wb_regwrite}, {31'b0, vecs[v].e_rw});
      check($sformatf("v%0d_wb_reg", v), {27'b0, wb_reg}, {27'b0, vecs[v].e_reg});
      check($sformatf("v%0d_wb_data", v), wb_data, vecs[v].e_data);
      check($sformatf("v%0d_rs_data", v), rs_data, vecs[v].e_rs);
      check($sformatf("v%0d_rt_data", v), rt_data, vecs[v].e_rt);
    end

    // Reset arriving while the latch holds a pending write to reg 5.
    drive(1'b1, 1'b0, 32'h0, 32'h77, 5'd5);
    rs_addr = 5'd5;
    rt_addr = 5'd3;
    @(posedge clk);
    #1;
    check("rstmid_bypass", rs_data, 32'h77);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rstmid_rs5", rs_data, 32'h0);
    check("rstmid_rt3", rt_data, 32'h0);
    check("rstmid_wb_regwrite", {31'b0, wb_regwrite}, 32'h0);
    check("rstmid_wb_reg", {27'b0, wb_reg}, 32'h0);
    check("rstmid_wb_data", wb_data, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("postrst_rs5", rs_data, 32'h0);
    rs_addr = 5'd8;
    #1;
    check("postrst_rs8", rs_data, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
